id_ex_issue: RTL and testbench
==============================

// Module: id_ex_issue
// PURPOSE
//  ID->EX issue register: the producer side of the execute-stage ALU operand/select interface.
//  Decodes a MIPS instruction into the 3-bit ALU select and forwards rs/rt operands from MEM/WB.
//  Builds the second operand (rt or extended immediate) and registers everything for one EX cycle.
//  Handles pipeline stall (hold) and flush (bubble).
// PARAMETERS
//  DATA_W   32  operand/result width
//  FWD_EN   1   1 = MEM/WB forwarding enabled; 0 = ID_rd1/ID_rd2 used unmodified
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  reset_n        in   1       synchronous, active-low reset
//  ID_valid       in   1       ID_instr/ID_rd1/ID_rd2 hold a real instruction
//  ID_instr       in   32      instruction word
//  ID_rd1         in   DATA_W  register-file read of rs
//  ID_rd2         in   DATA_W  register-file read of rt
//  EX_stall       in   1       hold all outputs this cycle
//  EX_flush       in   1       load a bubble this cycle
//  MEM_wr_en      in   1       MEM-stage result will write a register
//  MEM_wr_reg     in   5       MEM-stage destination
//  MEM_wr_data    in   DATA_W  MEM-stage result
//  WB_wr_en       in   1       WB-stage write enable
//  WB_wr_reg      in   5       WB-stage destination
//  WB_wr_data     in   DATA_W  WB-stage write data
//  EX_valid       out  1       EX slot holds a real instruction
//  EX_rd1         out  DATA_W  ALU operand A (forwarded rs)
//  EX_alu_in2     out  DATA_W  ALU operand B (forwarded rt or extended imm)
//  EX_alu_select  out  3       {negate_B, select_arith, select_or}
//  EX_rt_data     out  DATA_W  forwarded rt (store data)
//  EX_dest_reg    out  5       writeback register
//  EX_reg_write   out  1       writeback enable
//  EX_mem_op      out  2       00 none, 01 load, 10 store
//  EX_branch      out  2       00 none, 01 beq (taken on zero), 10 bne (taken on !zero)
//  EX_illegal     out  1       unsupported opcode/funct
// BEHAVIOUR
//  - reset_n=0 at edge: every output 0 (AND select, bubble). Reset beats flush and stall.
//  - Priority at each edge: reset > flush > stall > load. Flush loads a bubble even while stalled.
//  - Bubble: EX_valid=0, reg_write/mem_op/branch/illegal=0. Data outputs 0.
//  - Stall: all outputs hold. Load: outputs reflect ID inputs sampled at that edge; latency 1 cycle.
//  - ID_valid=0 on load -> bubble.
//  - Select codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
//  - R-type (op 0x00), funct -> select:
//    - 20/21 ADD; 22/23 SUB; 24 AND; 25 OR; 2A SLT.
//    - in2=rt; dest=rd.
//  - I-type, dest=rt:
//    - 08/09 ADD and 0A SLT, sign-extended imm.
//    - 0C AND and 0D OR, zero-extended imm.
//    - 23 lw: ADD, sext, mem_op=01.
//  - 2B sw: ADD, sext, mem_op=10, reg_write=0. 04/05 beq/bne: SUB, in2=rt, branch=01/10, reg_write=0.
//  - Other op/funct: EX_valid=1, EX_illegal=1, select=000, reg_write=mem_op=branch=0.
//  - reg_write forced 0 when dest_reg=0.
//  - Forwarding per source (rs, rt) when FWD_EN=1:
//    - MEM match (wr_en, reg==src, src!=0) first; else WB match; else ID_rdN.
//    - Both match -> MEM wins. Register 0 never forwarded.
//  - Forwarding is evaluated on inputs at the load edge.
//  - Hazards needing a stall (load-use) are detected outside; this block only obeys EX_stall.
// TESTING
//  - Reset: hold reset_n=0 with stall=1, flush=1 -> all outputs 0. Release -> remains a bubble until the first valid load.
//  - add $3,$1,$2 (0x00221820), rd1=5, rd2=7, no fwd -> next cycle: select=010, rd1=5, in2=7, dest=3, reg_write=1.
//  - andi $4,$1,0xFFFF / addi $4,$1,-1 -> in2=0x0000FFFF, select 000 / in2=0xFFFFFFFF, select 010.
//  - Forwarding on $1:
//    - MEM_wr_reg=1 (data 0xAA) and WB_wr_reg=1 (data 0xBB) -> EX_rd1=0xAA.
//    - MEM_wr_en=0 -> 0xBB.
//    - Source $0 with MEM_wr_reg=0 -> ID_rd1.
//  - Stall 3 cycles while ID changes -> outputs frozen. Stall+flush together -> bubble next cycle.
//  - op 0x3F -> EX_valid=1, illegal=1, reg_write=0. beq -> select 110, branch=01. sw -> mem_op=10, rt_data forwarded.

Source files
------------

// File: rtl/id_ex_issue.sv
// ID->EX issue register: decodes a MIPS instruction into ALU select/control,
// forwards rs/rt from MEM/WB, builds operand B and registers it all for EX.
module id_ex_issue #(
  parameter int DATA_W = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ID_valid,
  input  logic [31:0]       ID_instr,
  input  logic [DATA_W-1:0] ID_rd1,
  input  logic [DATA_W-1:0] ID_rd2,
  input  logic              EX_stall,
  input  logic              EX_flush,
  input  logic              MEM_wr_en,
  input  logic [4:0]        MEM_wr_reg,
  input  logic [DATA_W-1:0] MEM_wr_data,
  input  logic              WB_wr_en,
  input  logic [4:0]        WB_wr_reg,
  input  logic [DATA_W-1:0] WB_wr_data,
  output logic              EX_valid,
  output logic [DATA_W-1:0] EX_rd1,
  output logic [DATA_W-1:0] EX_alu_in2,
  output logic [2:0]        EX_alu_select,
  output logic [DATA_W-1:0] EX_rt_data,
  output logic [4:0]        EX_dest_reg,
  output logic              EX_reg_write,
  output logic [1:0]        EX_mem_op,
  output logic [1:0]        EX_branch,
  output logic              EX_illegal
);

  localparam logic [2:0] SEL_AND = 3'b000, SEL_OR  = 3'b001, SEL_ADD = 3'b010,
                         SEL_SUB = 3'b110, SEL_SLT = 3'b111;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] rt;
    logic [2:0]        sel;
    logic [4:0]        dest;
    logic              rw;
    logic [1:0]        mem;
    logic [1:0]        br;
    logic              ill;
  } ex_t;

  ex_t ex_d, ex_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  assign op    = ID_instr[31:26];
  assign rs    = ID_instr[25:21];
  assign rt    = ID_instr[20:16];
  assign rd    = ID_instr[15:11];
  assign funct = ID_instr[5:0];
  assign imm   = ID_instr[15:0];

  // MEM is younger than WB, so it wins when both target the same register.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [4:0] src, input logic [DATA_W-1:0] rf,
    input logic m_en, input logic [4:0] m_reg, input logic [DATA_W-1:0] m_data,
    input logic w_en, input logic [4:0] w_reg, input logic [DATA_W-1:0] w_data);
    if (!FWD_EN || src == 5'd0) return rf;
    if (m_en && m_reg == src)   return m_data;
    if (w_en && w_reg == src)   return w_data;
    return rf;
  endfunction

  logic [DATA_W-1:0] rs_val, rt_val, imm_s, imm_z;
  assign rs_val = fwd(rs, ID_rd1, MEM_wr_en, MEM_wr_reg, MEM_wr_data,
                      WB_wr_en, WB_wr_reg, WB_wr_data);
  assign rt_val = fwd(rt, ID_rd2, MEM_wr_en, MEM_wr_reg, MEM_wr_data,
                      WB_wr_en, WB_wr_reg, WB_wr_data);
  assign imm_s  = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_z  = {{(DATA_W-16){1'b0}}, imm};

  always_comb begin
    ex_d       = '0;
    ex_d.valid = 1'b1;
    ex_d.rd1   = rs_val;
    ex_d.rt    = rt_val;
    ex_d.in2   = rt_val;
    ex_d.sel   = SEL_AND;
    unique case (op)
      6'h00: begin
        ex_d.dest = rd;
        ex_d.rw   = 1'b1;
        case (funct)
          6'h20, 6'h21: ex_d.sel = SEL_ADD;
          6'h22, 6'h23: ex_d.sel = SEL_SUB;
          6'h24:        ex_d.sel = SEL_AND;
          6'h25:        ex_d.sel = SEL_OR;
          6'h2A:        ex_d.sel = SEL_SLT;
          default: begin
            ex_d.ill  = 1'b1;
            ex_d.rw   = 1'b0;
            ex_d.dest = 5'd0;
          end
        endcase
      end
      6'h08, 6'h09: begin ex_d.sel = SEL_ADD; ex_d.in2 = imm_s; ex_d.dest = rt; ex_d.rw = 1'b1; end
      6'h0A:        begin ex_d.sel = SEL_SLT; ex_d.in2 = imm_s; ex_d.dest = rt; ex_d.rw = 1'b1; end
      6'h0C:        begin ex_d.sel = SEL_AND; ex_d.in2 = imm_z; ex_d.dest = rt; ex_d.rw = 1'b1; end
      6'h0D:        begin ex_d.sel = SEL_OR;  ex_d.in2 = imm_z; ex_d.dest = rt; ex_d.rw = 1'b1; end
      6'h23: begin
        ex_d.sel = SEL_ADD; ex_d.in2 = imm_s; ex_d.dest = rt; ex_d.rw = 1'b1; ex_d.mem = 2'b01;
      end
      6'h2B: begin ex_d.sel = SEL_ADD; ex_d.in2 = imm_s; ex_d.mem = 2'b10; end
      6'h04: begin ex_d.sel = SEL_SUB; ex_d.br = 2'b01; end
      6'h05: begin ex_d.sel = SEL_SUB; ex_d.br = 2'b10; end
      default: ex_d.ill = 1'b1;
    endcase
    // Writes to $0 are architecturally discarded.
    if (ex_d.dest == 5'd0) ex_d.rw = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)       ex_q <= '0;
    else if (EX_flush)  ex_q <= '0;
    else if (EX_stall)  ex_q <= ex_q;
    else if (!ID_valid) ex_q <= '0;
    else                ex_q <= ex_d;
  end

  assign EX_valid      = ex_q.valid;
  assign EX_rd1        = ex_q.rd1;
  assign EX_alu_in2    = ex_q.in2;
  assign EX_alu_select = ex_q.sel;
  assign EX_rt_data    = ex_q.rt;
  assign EX_dest_reg   = ex_q.dest;
  assign EX_reg_write  = ex_q.rw;
  assign EX_mem_op     = ex_q.mem;
  assign EX_branch     = ex_q.br;
  assign EX_illegal    = ex_q.ill;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: decode, forwarding, stall/flush and reset.
module tb_id_ex_issue;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n, ID_valid, EX_stall, EX_flush;
  logic [31:0]   ID_instr;
  logic [W-1:0]  ID_rd1, ID_rd2, MEM_wr_data, WB_wr_data;
  logic          MEM_wr_en, WB_wr_en;
  logic [4:0]    MEM_wr_reg, WB_wr_reg;
  logic          EX_valid, EX_reg_write, EX_illegal;
  logic [W-1:0]  EX_rd1, EX_alu_in2, EX_rt_data;
  logic [2:0]    EX_alu_select;
  logic [4:0]    EX_dest_reg;
  logic [1:0]    EX_mem_op, EX_branch;

  int vecs = 0;
  int errs = 0;

  // {valid, select, dest, reg_write, mem_op, branch, illegal}
  logic [14:0] ctrl;
  assign ctrl = {EX_valid, EX_alu_select, EX_dest_reg, EX_reg_write, EX_mem_op, EX_branch, EX_illegal};

  id_ex_issue #(.DATA_W(W), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ID_valid(ID_valid), .ID_instr(ID_instr),
    .ID_rd1(ID_rd1), .ID_rd2(ID_rd2), .EX_stall(EX_stall), .EX_flush(EX_flush),
    .MEM_wr_en(MEM_wr_en), .MEM_wr_reg(MEM_wr_reg), .MEM_wr_data(MEM_wr_data),
    .WB_wr_en(WB_wr_en), .WB_wr_reg(WB_wr_reg), .WB_wr_data(WB_wr_data),
    .EX_valid(EX_valid), .EX_rd1(EX_rd1), .EX_alu_in2(EX_alu_in2),
    .EX_alu_select(EX_alu_select), .EX_rt_data(EX_rt_data), .EX_dest_reg(EX_dest_reg),
    .EX_reg_write(EX_reg_write), .EX_mem_op(EX_mem_op), .EX_branch(EX_branch),
    .EX_illegal(EX_illegal));

  always #5 clk = ~clk;

  task automatic quiet();
    EX_stall = 0; EX_flush = 0;
    MEM_wr_en = 0; MEM_wr_reg = 0; MEM_wr_data = 0;
    WB_wr_en = 0;  WB_wr_reg = 0;  WB_wr_data = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [W-1:0] a, input logic [W-1:0] b);
    ID_valid = 1; ID_instr = ins; ID_rd1 = a; ID_rd2 = b;
    step();
  endtask

  task automatic test_reset();
    reset_n = 0; EX_stall = 1; EX_flush = 1;
    ID_valid = 1; ID_instr = 32'h00221820; ID_rd1 = 5; ID_rd2 = 7;
    step(); step();
    vecs++;
    if ({ctrl, EX_rd1, EX_alu_in2, EX_rt_data} !== '0) begin
      errs++; $display("FAIL reset: ctrl=%h rd1=%h in2=%h rt=%h want all 0", ctrl, EX_rd1, EX_alu_in2, EX_rt_data);
    end
    reset_n = 1; quiet(); ID_valid = 0;
    step(); step();
    vecs++;
    if ({ctrl, EX_rd1} !== '0) begin
      errs++; $display("FAIL reset_release: ctrl=%h rd1=%h want 0", ctrl, EX_rd1);
    end
  endtask

  task automatic test_rtype();
    quiet();
    issue(32'h00221820, 5, 7);
    vecs++;
    if (ctrl !== {1'b1, 3'b010, 5'd3, 1'b1, 2'b00, 2'b00, 1'b0} || EX_rd1 !== 5 || EX_alu_in2 !== 7) begin
      errs++; $display("FAIL add: ctrl=%h rd1=%h in2=%h want ctrl=%h rd1=5 in2=7", ctrl, EX_rd1, EX_alu_in2,
                       {1'b1, 3'b010, 5'd3, 1'b1, 4'b0, 1'b0});
    end
    issue(32'h00220020, 5, 7);  // add $0,$1,$2
    vecs++;
    if (EX_reg_write !== 1'b0 || EX_dest_reg !== 5'd0) begin
      errs++; $display("FAIL add_r0: reg_write=%b dest=%0d want 0/0", EX_reg_write, EX_dest_reg);
    end
    ID_valid = 0; step();
    vecs++;
    if ({ctrl, EX_rd1} !== '0) begin
      errs++; $display("FAIL id_invalid: ctrl=%h rd1=%h want 0", ctrl, EX_rd1);
    end
  endtask

  task automatic test_imm();
    quiet();
    issue(32'h3024FFFF, 3, 9);  // andi $4,$1,0xFFFF
    vecs++;
    if (EX_alu_in2 !== 32'h0000FFFF || ctrl !== {1'b1, 3'b000, 5'd4, 1'b1, 4'b0, 1'b0}) begin
      errs++; $display("FAIL andi: in2=%h ctrl=%h want in2=0000ffff", EX_alu_in2, ctrl);
    end
    issue(32'h2024FFFF, 3, 9);  // addi $4,$1,-1
    vecs++;
    if (EX_alu_in2 !== 32'hFFFFFFFF || ctrl !== {1'b1, 3'b010, 5'd4, 1'b1, 4'b0, 1'b0}) begin
      errs++; $display("FAIL addi: in2=%h ctrl=%h want in2=ffffffff", EX_alu_in2, ctrl);
    end
    issue(32'h8C25FFFC, 3, 9);  // lw $5,-4($1)
    vecs++;
    if (EX_alu_in2 !== 32'hFFFFFFFC || ctrl !== {1'b1, 3'b010, 5'd5, 1'b1, 2'b01, 2'b00, 1'b0}) begin
      errs++; $display("FAIL lw: in2=%h ctrl=%h want in2=fffffffc mem=01", EX_alu_in2, ctrl);
    end
  endtask

  task automatic test_fwd();
    quiet();
    MEM_wr_en = 1; MEM_wr_reg = 1; MEM_wr_data = 32'hAA;
    WB_wr_en  = 1; WB_wr_reg  = 1; WB_wr_data  = 32'hBB;
    issue(32'h00221820, 5, 7);
    vecs++;
    if (EX_rd1 !== 32'hAA || EX_alu_in2 !== 7) begin
      errs++; $display("FAIL fwd_mem_wins: rd1=%h in2=%h want aa/7", EX_rd1, EX_alu_in2);
    end
    MEM_wr_en = 0;
    issue(32'h00221820, 5, 7);
    vecs++;
    if (EX_rd1 !== 32'hBB) begin
      errs++; $display("FAIL fwd_wb: rd1=%h want bb", EX_rd1);
    end
    MEM_wr_en = 1; MEM_wr_reg = 0; WB_wr_reg = 2; WB_wr_data = 32'hCC;
    issue(32'h00021820, 32'h55, 7);  // add $3,$0,$2
    vecs++;
    if (EX_rd1 !== 32'h55 || EX_alu_in2 !== 32'hCC || EX_rt_data !== 32'hCC) begin
      errs++; $display("FAIL fwd_r0: rd1=%h in2=%h rt=%h want 55/cc/cc", EX_rd1, EX_alu_in2, EX_rt_data);
    end
  endtask

  task automatic test_stall_flush();
    quiet();
    issue(32'h00221820, 5, 7);
    EX_stall = 1;
    for (int i = 0; i < 3; i++) begin
      issue(32'h2024FFFF + i, 99 + i, 77);
      vecs++;
      if (EX_rd1 !== 5 || EX_alu_in2 !== 7 || ctrl !== {1'b1, 3'b010, 5'd3, 1'b1, 4'b0, 1'b0}) begin
        errs++; $display("FAIL stall_%0d: rd1=%h in2=%h ctrl=%h want frozen add", i, EX_rd1, EX_alu_in2, ctrl);
      end
    end
    EX_flush = 1;
    issue(32'h00221820, 5, 7);
    vecs++;
    if ({ctrl, EX_rd1, EX_alu_in2} !== '0) begin
      errs++; $display("FAIL stall_flush: ctrl=%h rd1=%h in2=%h want bubble", ctrl, EX_rd1, EX_alu_in2);
    end
  endtask

  task automatic test_illegal_branch_store();
    quiet();
    issue(32'hFC000000, 1, 2);
    vecs++;
    if (EX_valid !== 1 || EX_illegal !== 1 || EX_reg_write !== 0 || EX_alu_select !== 3'b000
        || EX_mem_op !== 0 || EX_branch !== 0) begin
      errs++; $display("FAIL illegal_op: ctrl=%h want valid=1 ill=1 rest 0", ctrl);
    end
    issue(32'h10220004, 5, 7);  // beq $1,$2
    vecs++;
    if (ctrl !== {1'b1, 3'b110, 5'd0, 1'b0, 2'b00, 2'b01, 1'b0} || EX_alu_in2 !== 7) begin
      errs++; $display("FAIL beq: ctrl=%h in2=%h want sel=110 br=01 in2=7", ctrl, EX_alu_in2);
    end
    issue(32'h14220004, 5, 7);  // bne
    vecs++;
    if (EX_branch !== 2'b10 || EX_alu_select !== 3'b110 || EX_reg_write !== 0) begin
      errs++; $display("FAIL bne: br=%b sel=%b rw=%b want 10/110/0", EX_branch, EX_alu_select, EX_reg_write);
    end
    MEM_wr_en = 1; MEM_wr_reg = 2; MEM_wr_data = 32'h1234;
    issue(32'hAC220008, 5, 7);  // sw $2,8($1)
    vecs++;
    if (EX_mem_op !== 2'b10 || EX_reg_write !== 0 || EX_rt_data !== 32'h1234 || EX_alu_in2 !== 8
        || EX_alu_select !== 3'b010) begin
      errs++; $display("FAIL sw: mem=%b rw=%b rt=%h in2=%h sel=%b want 10/0/1234/8/010",
                       EX_mem_op, EX_reg_write, EX_rt_data, EX_alu_in2, EX_alu_select);
    end
    MEM_wr_en = 0;
    issue(32'h0022182F, 5, 7);  // unsupported funct 0x2F
    vecs++;
    if (EX_illegal !== 1 || EX_reg_write !== 0 || EX_valid !== 1) begin
      errs++; $display("FAIL illegal_funct: ill=%b rw=%b v=%b want 1/0/1", EX_illegal, EX_reg_write, EX_valid);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_fwd();
    test_stall_flush();
    test_illegal_branch_store();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
